// File: rtl/cpu_axi_master_bridge.sv
// Single-beat AXI4 master bridge for one CPU memory port; stalls the core until the access completes.
// Optional feature: define AXI_BRIDGE_ERR_EN to make non-OKAY R/B responses set a sticky cpu_err.
module cpu_axi_master_bridge #(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q, w_done_q, done_q;
    logic        accept, r_beat, b_beat, aw_fire, w_fire;

    // Handshakes: a transfer happens on any rising clk edge where VALID && READY.
    // VALID is held, with its payload stable, until that edge; READY is only
    // raised in the state that consumes the channel, so early beats wait.
    always_comb begin
        state_d = state_q;
        accept  = (state_q == S_IDLE) && cpu_req && !done_q;
        r_beat  = (state_q == S_RDATA) && RVALID && (RID == MASTER_ID) && RLAST;
        b_beat  = (state_q == S_WRESP) && BVALID && (BID == MASTER_ID);
        aw_fire = AWVALID && AWREADY;
        w_fire  = WVALID && WREADY;
        case (state_q)
            S_IDLE:  if (accept) state_d = cpu_we ? S_WREQ : S_RADDR;
            S_RADDR: if (ARREADY) state_d = S_RDATA;
            S_RDATA: if (r_beat) state_d = S_IDLE;
            S_WREQ:  if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state_d = S_WRESP;
            S_WRESP: if (b_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= r_beat || b_beat;
            if (accept) begin
                addr_q    <= cpu_addr;
                wdata_q   <= cpu_wdata;
                wstrb_q   <= cpu_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_fire) aw_done_q <= 1'b1;
                if (w_fire)  w_done_q  <= 1'b1;
            end
            if (r_beat) rdata_q <= RDATA;
        end
    end

`ifdef AXI_BRIDGE_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if ((r_beat && (RRESP != 2'b00)) || (b_beat && (BRESP != 2'b00))) err_q <= 1'b1;
    end
    assign cpu_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{RRESP, BRESP};
    assign cpu_err     = 1'b0;
`endif

    // The done cycle releases the core but does not accept its next request.
    assign cpu_stall = rst && ((state_q != S_IDLE) || (cpu_req && !done_q));
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = (state_q == S_RADDR);
    assign RREADY  = (state_q == S_RDATA);

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = (state_q == S_WREQ) && !aw_done_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = (state_q == S_WREQ) && !w_done_q;
    assign BREADY  = (state_q == S_WRESP);

    assign dbg_state = state_q;

endmodule
